// File: rtl/pu_layer_sched.sv
// pu_layer_sched: sequences one PU through a fully-connected layer.
// Clear, MAC over all chunks, wait for the PU pipeline, write back.
module pu_layer_sched #(
    parameter int WADDR_WIDTH = 7,
    parameter int RADDR_WIDTH = 7,
    parameter int CADDR_WIDTH = 5,
    parameter int BADDR_WIDTH = 3,
    parameter int PU_LAT      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WADDR_WIDTH-1:0] cfg_num_chunks,
    input  logic [CADDR_WIDTH-1:0] cfg_num_out,
    input  logic [WADDR_WIDTH-1:0] cfg_w_base,
    input  logic [RADDR_WIDTH-1:0] cfg_r_base,
    input  logic [BADDR_WIDTH-1:0] cfg_bias_addr,
    input  logic                   cfg_add_bias,
    input  logic                   cfg_relu,
    input  logic                   data_valid,
    output logic                   data_req,
    output logic                   busy,
    output logic                   job_done,
    output logic                   out_mac_en,
    output logic                   out_cache_wr_en,
    output logic                   out_done,
    output logic                   out_add_bias,
    output logic                   out_relu,
    output logic                   out_cache_clear,
    output logic [CADDR_WIDTH-1:0] out_cache_rd_addr,
    output logic [CADDR_WIDTH-1:0] out_cache_wr_addr,
    output logic [WADDR_WIDTH-1:0] out_w_rd_addr,
    output logic [BADDR_WIDTH-1:0] out_bias_addr,
    output logic                   out_r_wr_en,
    output logic [RADDR_WIDTH-1:0] out_r_wr_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_WAIT,
        S_WB,
        S_FIN
    } state_t;

    localparam logic [WADDR_WIDTH-1:0] W_ONE = 1;
    localparam logic [CADDR_WIDTH-1:0] C_ONE = 1;
    localparam logic [2:0] WAIT_INIT = 3'(PU_LAT - 1);

    state_t                 state;
    logic [WADDR_WIDTH-1:0] num_chunks_q;
    logic [CADDR_WIDTH-1:0] num_out_q;
    logic [RADDR_WIDTH-1:0] r_base_q;
    logic [BADDR_WIDTH-1:0] bias_base_q;
    logic                   add_bias_q;
    logic                   relu_q;
    logic [WADDR_WIDTH-1:0] w_ptr;
    logic [WADDR_WIDTH-1:0] chunk_idx;
    logic [CADDR_WIDTH-1:0] out_idx;
    logic [2:0]             wait_cnt;

    logic                   last_chunk;
    logic                   last_out;
    logic [CADDR_WIDTH-1:0] out_nxt;

    // End-of-output and end-of-layer detection on the latched counts
    assign last_chunk = (chunk_idx == num_chunks_q - W_ONE);
    assign last_out   = (out_idx == num_out_q - C_ONE);
    assign out_nxt    = out_idx + C_ONE;

    // Layer FSM; every PU-facing output is a register driven here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            num_chunks_q      <= '0;
            num_out_q         <= '0;
            r_base_q          <= '0;
            bias_base_q       <= '0;
            add_bias_q        <= 1'b0;
            relu_q            <= 1'b0;
            w_ptr             <= '0;
            chunk_idx         <= '0;
            out_idx           <= '0;
            wait_cnt          <= '0;
            data_req          <= 1'b0;
            busy              <= 1'b0;
            job_done          <= 1'b0;
            out_mac_en        <= 1'b0;
            out_cache_wr_en   <= 1'b0;
            out_done          <= 1'b0;
            out_add_bias      <= 1'b0;
            out_relu          <= 1'b0;
            out_cache_clear   <= 1'b1;
            out_cache_rd_addr <= '0;
            out_cache_wr_addr <= '0;
            out_w_rd_addr     <= '0;
            out_bias_addr     <= '0;
            out_r_wr_en       <= 1'b0;
            out_r_wr_addr     <= '0;
        end else begin
            job_done        <= 1'b0;
            out_mac_en      <= 1'b0;
            out_cache_wr_en <= 1'b0;
            out_done        <= 1'b0;
            out_add_bias    <= 1'b0;
            out_relu        <= 1'b0;
            out_cache_clear <= 1'b1;
            out_r_wr_en     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy              <= 1'b1;
                        num_chunks_q      <= cfg_num_chunks;
                        num_out_q         <= cfg_num_out;
                        r_base_q          <= cfg_r_base;
                        bias_base_q       <= cfg_bias_addr;
                        add_bias_q        <= cfg_add_bias;
                        relu_q            <= cfg_relu;
                        w_ptr             <= cfg_w_base;
                        chunk_idx         <= '0;
                        out_idx           <= '0;
                        out_cache_rd_addr <= '0;
                        out_cache_wr_addr <= '0;
                        out_bias_addr     <= cfg_bias_addr;
                        if (cfg_num_chunks == '0 || cfg_num_out == '0) begin
                            state <= S_FIN;
                        end else begin
                            state           <= S_CLEAR;
                            out_cache_clear <= 1'b0;
                        end
                    end
                end
                S_CLEAR: begin
                    state    <= S_MAC;
                    data_req <= 1'b1;
                end
                S_MAC: begin
                    if (data_valid) begin
                        out_mac_en      <= 1'b1;
                        out_cache_wr_en <= 1'b1;
                        out_w_rd_addr   <= w_ptr;
                        w_ptr           <= w_ptr + W_ONE;
                        chunk_idx       <= chunk_idx + W_ONE;
                        if (last_chunk) begin
                            out_done     <= 1'b1;
                            out_add_bias <= add_bias_q;
                            out_relu     <= relu_q;
                            data_req     <= 1'b0;
                            wait_cnt     <= WAIT_INIT;
                            state        <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state         <= S_WB;
                        out_r_wr_en   <= 1'b1;
                        out_r_wr_addr <= r_base_q + RADDR_WIDTH'(out_idx);
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_WB: begin
                    if (last_out) begin
                        state <= S_FIN;
                    end else begin
                        out_idx           <= out_nxt;
                        chunk_idx         <= '0;
                        out_cache_rd_addr <= out_nxt;
                        out_cache_wr_addr <= out_nxt;
                        out_bias_addr     <= bias_base_q + BADDR_WIDTH'(out_nxt);
                        out_cache_clear   <= 1'b0;
                        state             <= S_CLEAR;
                    end
                end
                S_FIN: begin
                    job_done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pu_layer_sched.sv
// tb_pu_layer_sched: directed self-checking bench for pu_layer_sched.
// Cycle-exact checks plus logged address sequences per job.
module tb_pu_layer_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] cfg_num_chunks;
    logic [4:0] cfg_num_out;
    logic [6:0] cfg_w_base;
    logic [6:0] cfg_r_base;
    logic [2:0] cfg_bias_addr;
    logic       cfg_add_bias;
    logic       cfg_relu;
    logic       data_valid;
    logic       data_req;
    logic       busy;
    logic       job_done;
    logic       out_mac_en;
    logic       out_cache_wr_en;
    logic       out_done;
    logic       out_add_bias;
    logic       out_relu;
    logic       out_cache_clear;
    logic [4:0] out_cache_rd_addr;
    logic [4:0] out_cache_wr_addr;
    logic [6:0] out_w_rd_addr;
    logic [2:0] out_bias_addr;
    logic       out_r_wr_en;
    logic [6:0] out_r_wr_addr;

    int n_assert;
    int n_fail;

    logic [6:0] wq[$];
    logic [6:0] rq[$];
    logic [2:0] bq[$];
    logic [1:0] fq[$];
    int         clr_cnt;
    int         jd_cnt;

    pu_layer_sched #(
        .WADDR_WIDTH(7),
        .RADDR_WIDTH(7),
        .CADDR_WIDTH(5),
        .BADDR_WIDTH(3),
        .PU_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_num_chunks(cfg_num_chunks),
        .cfg_num_out(cfg_num_out),
        .cfg_w_base(cfg_w_base),
        .cfg_r_base(cfg_r_base),
        .cfg_bias_addr(cfg_bias_addr),
        .cfg_add_bias(cfg_add_bias),
        .cfg_relu(cfg_relu),
        .data_valid(data_valid),
        .data_req(data_req),
        .busy(busy),
        .job_done(job_done),
        .out_mac_en(out_mac_en),
        .out_cache_wr_en(out_cache_wr_en),
        .out_done(out_done),
        .out_add_bias(out_add_bias),
        .out_relu(out_relu),
        .out_cache_clear(out_cache_clear),
        .out_cache_rd_addr(out_cache_rd_addr),
        .out_cache_wr_addr(out_cache_wr_addr),
        .out_w_rd_addr(out_w_rd_addr),
        .out_bias_addr(out_bias_addr),
        .out_r_wr_en(out_r_wr_en),
        .out_r_wr_addr(out_r_wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log PU-side activity mid-cycle for sequence checks
    always @(negedge clk) begin
        if (!rst) begin
            if (out_mac_en) wq.push_back(out_w_rd_addr);
            if (out_r_wr_en) rq.push_back(out_r_wr_addr);
            if (out_done) begin
                bq.push_back(out_bias_addr);
                fq.push_back({out_add_bias, out_relu});
            end
            if (!out_cache_clear) clr_cnt++;
            if (job_done) jd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq.delete();
        rq.delete();
        bq.delete();
        fq.delete();
        clr_cnt = 0;
        jd_cnt  = 0;
    endtask

    function automatic logic [31:0] wat(input int i);
        return (i < wq.size()) ? 32'(wq[i]) : 32'hdead;
    endfunction

    function automatic logic [31:0] rat(input int i);
        return (i < rq.size()) ? 32'(rq[i]) : 32'hdead;
    endfunction

    task automatic set_cfg(input int ch, input int no, input int wb,
                           input int rb, input int ba, input bit ab,
                           input bit rl);
        cfg_num_chunks = 7'(ch);
        cfg_num_out    = 5'(no);
        cfg_w_base     = 7'(wb);
        cfg_r_base     = 7'(rb);
        cfg_bias_addr  = 3'(ba);
        cfg_add_bias   = ab;
        cfg_relu       = rl;
    endtask

    task automatic wait_done(input bit glitch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            if (job_done) seen = 1'b1;
            if (glitch && i == 2) begin
                start       = 1'b1;
                cfg_num_out = 5'd9;
            end
            if (i == 3) start = 1'b0;
        end
        chk("job_done_seen", 32'(seen), 32'd1);
        step();
        step();
        chk("busy_after_job", 32'(busy), 32'd0);
    endtask

    task automatic run_job(input int ch, input int no, input int wb,
                           input int rb, input int ba, input bit ab,
                           input bit rl, input bit glitch);
        clear_log();
        set_cfg(ch, no, wb, rb, ba, ab, rl);
        data_valid = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        wait_done(glitch);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        data_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 1'b0, 1'b0);
        clear_log();
        #12;
        chk("rst_cache_clear", 32'(out_cache_clear), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data_req", 32'(data_req), 32'd0);
        chk("rst_mac_en", 32'(out_mac_en), 32'd0);
        chk("rst_r_wr_en", 32'(out_r_wr_en), 32'd0);
        rst = 1'b0;
        step();

        // Two chunks, one output: cycle-exact
        set_cfg(2, 1, 0, 0, 0, 1'b1, 1'b0);
        data_valid = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_clear", 32'(out_cache_clear), 32'd0);
        step();
        chk("t1_req", 32'(data_req), 32'd1);
        chk("t1_clear_off", 32'(out_cache_clear), 32'd1);
        chk("t1_mac_pre", 32'(out_mac_en), 32'd0);
        step();
        chk("t1_mac0", 32'(out_mac_en), 32'd1);
        chk("t1_wadr0", 32'(out_w_rd_addr), 32'd0);
        chk("t1_done0", 32'(out_done), 32'd0);
        step();
        chk("t1_mac1", 32'(out_mac_en), 32'd1);
        chk("t1_cwr1", 32'(out_cache_wr_en), 32'd1);
        chk("t1_wadr1", 32'(out_w_rd_addr), 32'd1);
        chk("t1_done1", 32'(out_done), 32'd1);
        chk("t1_addb", 32'(out_add_bias), 32'd1);
        chk("t1_relu", 32'(out_relu), 32'd0);
        chk("t1_req_off", 32'(data_req), 32'd0);
        step();
        chk("t1_wait_mac", 32'(out_mac_en), 32'd0);
        chk("t1_wait_rwr", 32'(out_r_wr_en), 32'd0);
        step();
        chk("t1_rwr", 32'(out_r_wr_en), 32'd1);
        chk("t1_radr", 32'(out_r_wr_addr), 32'd0);
        step();
        chk("t1_rwr_off", 32'(out_r_wr_en), 32'd0);
        chk("t1_jd_early", 32'(job_done), 32'd0);
        step();
        chk("t1_jd", 32'(job_done), 32'd1);
        chk("t1_busy_jd", 32'(busy), 32'd1);
        step();
        chk("t1_jd_off", 32'(job_done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        step();

        // Three chunks, two outputs, start glitch while busy
        run_job(3, 2, 5, 10, 0, 1'b0, 1'b0, 1'b1);
        chk("t2_wcnt", 32'(wq.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("t2_wadr", wat(i), 32'(5 + i));
        chk("t2_rcnt", 32'(rq.size()), 32'd2);
        chk("t2_radr0", rat(0), 32'd10);
        chk("t2_radr1", rat(1), 32'd11);
        chk("t2_clears", 32'(clr_cnt), 32'd2);
        chk("t2_jd", 32'(jd_cnt), 32'd1);

        // Stall: data_valid 1,0,0,1 inside MAC
        clear_log();
        set_cfg(2, 1, 20, 0, 0, 1'b0, 1'b0);
        data_valid = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t3_req", 32'(data_req), 32'd1);
        data_valid = 1'b1;
        step();
        chk("t3_mac_a", 32'(out_mac_en), 32'd1);
        chk("t3_wadr_a", 32'(out_w_rd_addr), 32'd20);
        data_valid = 1'b0;
        step();
        chk("t3_mac_b", 32'(out_mac_en), 32'd0);
        chk("t3_cwr_b", 32'(out_cache_wr_en), 32'd0);
        chk("t3_wadr_b", 32'(out_w_rd_addr), 32'd20);
        step();
        chk("t3_mac_c", 32'(out_mac_en), 32'd0);
        chk("t3_wadr_c", 32'(out_w_rd_addr), 32'd20);
        chk("t3_req_c", 32'(data_req), 32'd1);
        data_valid = 1'b1;
        step();
        chk("t3_mac_d", 32'(out_mac_en), 32'd1);
        chk("t3_wadr_d", 32'(out_w_rd_addr), 32'd21);
        chk("t3_done_d", 32'(out_done), 32'd1);
        wait_done(1'b0);
        chk("t3_wcnt", 32'(wq.size()), 32'd2);

        // Address wrap on wmem, rmem and bias
        run_job(4, 2, 126, 127, 7, 1'b1, 1'b1, 1'b0);
        chk("t4_wcnt", 32'(wq.size()), 32'd8);
        chk("t4_w0", wat(0), 32'd126);
        chk("t4_w1", wat(1), 32'd127);
        chk("t4_w2", wat(2), 32'd0);
        chk("t4_w3", wat(3), 32'd1);
        chk("t4_w7", wat(7), 32'd5);
        chk("t4_r0", rat(0), 32'd127);
        chk("t4_r1", rat(1), 32'd0);
        chk("t4_bcnt", 32'(bq.size()), 32'd2);
        if (bq.size() == 2) begin
            chk("t4_b0", 32'(bq[0]), 32'd7);
            chk("t4_b1", 32'(bq[1]), 32'd0);
            chk("t4_flags", 32'(fq[1]), 32'd3);
        end

        // Empty jobs
        for (int k = 0; k < 2; k++) begin
            clear_log();
            set_cfg(k == 0 ? 0 : 3, k == 0 ? 4 : 0, 0, 0, 0, 1'b0, 1'b0);
            data_valid = 1'b1;
            start      = 1'b1;
            step();
            start = 1'b0;
            chk("t5_busy", 32'(busy), 32'd1);
            chk("t5_jd1", 32'(job_done), 32'd0);
            step();
            chk("t5_jd2", 32'(job_done), 32'd1);
            step();
            step();
            chk("t5_idle", 32'(busy), 32'd0);
            chk("t5_nomac", 32'(wq.size()), 32'd0);
            chk("t5_norwr", 32'(rq.size()), 32'd0);
            chk("t5_noclr", 32'(clr_cnt), 32'd0);
        end

        // Reset mid-MAC, then a clean job
        clear_log();
        set_cfg(4, 1, 0, 0, 0, 1'b0, 1'b0);
        data_valid = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("t6_mac_pre", 32'(out_mac_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_mac", 32'(out_mac_en), 32'd0);
        chk("t6_req", 32'(data_req), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_clear", 32'(out_cache_clear), 32'd1);
        chk("t6_wadr", 32'(out_w_rd_addr), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("t6_norwr", 32'(rq.size()), 32'd0);
        chk("t6_nojd", 32'(jd_cnt), 32'd0);
        run_job(1, 1, 9, 3, 2, 1'b0, 1'b0, 1'b0);
        chk("t6_wcnt", 32'(wq.size()), 32'd1);
        chk("t6_w0", wat(0), 32'd9);
        chk("t6_rcnt", 32'(rq.size()), 32'd1);
        chk("t6_r0", rat(0), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
